// File: rtl/sr_mdu_pkg.sv
// Shared types and constants for the MDU sequencer slice (states, funct3 op codes, watchdog default).
package sr_mdu_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_WB    = 3'd4
    } mdu_seq_state_e;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    localparam int unsigned MDU_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/sr_mdu_watchdog.sv
// WAIT-cycle watchdog: cleared on entry to WAIT, counts enabled cycles, flags the last allowed one.
module sr_mdu_watchdog #(
    parameter int unsigned LIMIT = 64,
    parameter int unsigned W     = 7
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [W-1:0] r_count;
    logic         w_at_limit;

    assign w_at_limit = (r_count == W'(LIMIT - 1));
    assign o_expired  = i_en & w_at_limit;

    // Saturating WAIT-cycle counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !w_at_limit) begin
            r_count <= r_count + W'(1);
        end
    end

endmodule

// File: rtl/sr_mdu_sequencer.sv
// Multi-cycle sequencer between decoder and MDU: freeze fetch, clear, launch, wait, write back.
// Optional WAIT watchdog and sticky mdu_err are built only when SR_MDU_TIMEOUT_EN is defined.
module sr_mdu_sequencer
    import sr_mdu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = MDU_TIMEOUT_CYCLES,
    parameter int unsigned TIMEOUT_W      = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd_op,
    input  logic [4:0]  cmd_rd,
    output logic        stall,
    output logic        mdu_clear,
    output logic        mdu_vld_in,
    output logic [2:0]  mdu_op,
    input  logic        mdu_vld_out,
    input  logic [31:0] mdu_result,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        mdu_err
);

    localparam bit P_CFG_OK = (TIMEOUT_CYCLES >= 2) &&
                              ((64'd1 << TIMEOUT_W) > 64'(TIMEOUT_CYCLES));

    generate
        if (!P_CFG_OK) begin : g_illegal_timeout_cfg
        end
    endgenerate

    mdu_seq_state_e r_state;
    mdu_seq_state_e w_next;
    logic [2:0]     r_op;
    logic [4:0]     r_rd;
    logic [31:0]    r_wb_data;
    logic           r_mdu_clear;
    logic           r_mdu_vld_in;
    logic           r_wb_en;
    logic           w_accept;
    logic           w_result;
    logic           w_timeout;

    // rd=0 retires as a NOP without touching the MDU.
    assign w_accept = (r_state == S_IDLE) & cmd_valid & (cmd_rd != 5'd0);
    assign w_result = (r_state == S_WAIT) & mdu_vld_out;
    assign stall    = reset_n & (((r_state != S_IDLE) & (r_state != S_WB)) | w_accept);

`ifdef SR_MDU_TIMEOUT_EN
    logic w_wd_clr;
    logic w_wd_en;
    logic w_wd_expired;
    logic r_mdu_err;

    assign w_wd_clr  = (r_state == S_ISSUE);
    assign w_wd_en   = (r_state == S_WAIT);
    // A result on the final counted cycle takes priority over the timeout.
    assign w_timeout = w_wd_expired & ~mdu_vld_out;
    assign mdu_err   = r_mdu_err;

    sr_mdu_watchdog #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (TIMEOUT_W)
    ) u_watchdog (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clr     (w_wd_clr),
        .i_en      (w_wd_en),
        .o_expired (w_wd_expired)
    );

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mdu_err <= 1'b0;
        end else begin
            r_mdu_err <= r_mdu_err | w_timeout;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign mdu_err   = 1'b0;
`endif

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? S_CLR : S_IDLE;
            S_CLR:   w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  begin
                if (mdu_vld_out || w_timeout) begin
                    w_next = S_WB;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_WB:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State, latched command and registered MDU / write-back outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_op         <= 3'd0;
            r_rd         <= 5'd0;
            r_wb_data    <= 32'd0;
            r_mdu_clear  <= 1'b0;
            r_mdu_vld_in <= 1'b0;
            r_wb_en      <= 1'b0;
        end else begin
            r_state      <= w_next;
            if (w_accept) begin
                r_op <= cmd_op;
                r_rd <= cmd_rd;
            end
            if (w_result) begin
                r_wb_data <= mdu_result;
            end
            // Timeout WB reuses the clear pulse to abort the stuck MDU.
            r_mdu_clear  <= (w_next == S_CLR) | w_timeout;
            r_mdu_vld_in <= (w_next == S_ISSUE);
            r_wb_en      <= w_result;
        end
    end

    assign mdu_clear  = r_mdu_clear;
    assign mdu_vld_in = r_mdu_vld_in;
    assign mdu_op     = r_op;
    assign wb_en      = r_wb_en;
    assign wb_rd      = r_rd;
    assign wb_data    = r_wb_data;

endmodule
